// File: rtl/ep_result_pipe.sv
// ----------------------------------------------------------------------------
// ep_result_pipe
//
// Result shift pipeline that sits after the even execution pipe. It captures
// the even-pipe packet on every clock and moves it through DEPTH result
// stages. All writebacks leave from the last stage, so they retire in program
// order whatever each unit's latency is.
// A packet counts as "ready" (its value is final) in stage k when k >= its
// unit latency. The same stages provide operand forwarding and hazard data.
//
// Ports:
//   clock                 system clock, rising edge
//   reset                 asynchronous, active-low reset
//   ep_in[142:0]          packet: [127:0] value, [134:128] rt address,
//                         [135] write enable, [142:136] unit latency
//   flush                 kill the entries now in stages 1 and 2 at this edge
//   fwd_addr_a/b/c        source register addresses to look up
//   fwd_hit_a/b/c         youngest matching producer is ready
//   fwd_pend_a/b/c        youngest matching producer is not ready (RAW hazard)
//   fwd_data_a/b/c        forwarded value, 0 when there is no hit
//   stage_valid[6:0]      bit k-1 = stage k holds a live write
//   stage_addr[48:0]      stage k address at [(k-1)*7 +: 7]
//   wb_en/wb_addr/wb_data register-file write port, taken from stage DEPTH
// ----------------------------------------------------------------------------
module ep_result_pipe #(
  parameter int DEPTH  = 7,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [142:0]              ep_in,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         fwd_addr_a,
  input  logic [ADDR_W-1:0]         fwd_addr_b,
  input  logic [ADDR_W-1:0]         fwd_addr_c,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b,
  output logic                      fwd_hit_c,
  output logic                      fwd_pend_a,
  output logic                      fwd_pend_b,
  output logic                      fwd_pend_c,
  output logic [DATA_W-1:0]         fwd_data_a,
  output logic [DATA_W-1:0]         fwd_data_b,
  output logic [DATA_W-1:0]         fwd_data_c,
  output logic [DEPTH-1:0]          stage_valid,
  output logic [DEPTH*ADDR_W-1:0]   stage_addr,
  output logic                      wb_en,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic [DATA_W-1:0]         wb_data
);

  localparam int LAT_IN_W = 7;
  localparam int LAT_W    = $clog2(DEPTH + 1);
  localparam logic [LAT_IN_W-1:0] LAT_MAX = LAT_IN_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [LAT_W-1:0]  lat;
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic              pend;
    logic [DATA_W-1:0] data;
  } fwd_t;

  entry_t [DEPTH:1] r_stage;

  entry_t              w_in;
  logic [LAT_IN_W-1:0] w_lat_raw;
  logic [LAT_IN_W-1:0] w_lat_norm;
  fwd_t                w_fwd_a;
  fwd_t                w_fwd_b;
  fwd_t                w_fwd_c;

  // Incoming packet. A latency of 0 is treated as 1 so that every result can
  // be ready no earlier than stage 1. Latencies above DEPTH saturate, because
  // nothing can take longer than the pipe is deep.
  assign w_lat_raw = ep_in[142:136];

  always_comb begin
    if (w_lat_raw == '0)          w_lat_norm = LAT_IN_W'(1);
    else if (w_lat_raw > LAT_MAX) w_lat_norm = LAT_MAX;
    else                          w_lat_norm = w_lat_raw;
  end

  assign w_in.value = ep_in[DATA_W-1:0];
  assign w_in.addr  = ep_in[134:128];
  assign w_in.valid = ep_in[135];
  assign w_in.lat   = w_lat_norm[LAT_W-1:0];

  // Shift pipeline. There is no stall: every stage advances on every edge.
  // NOTE: all stage state is cleared by reset, not only the valid bits. The
  // address and value fields are visible on stage_addr and the forwarding and
  // writeback outputs, and all of those must read 0 in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stage <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's pre-edge value. Blocking assignments would collapse the shift.
      r_stage[1] <= w_in;
      for (int k = 2; k <= DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
      // A flush kills the two youngest entries that are already in the pipe
      // (they are younger than the mispredicted branch). The incoming packet
      // is still captured into stage 1.
      if (flush) begin
        r_stage[2].valid <= 1'b0;
        r_stage[3].valid <= 1'b0;
      end
    end
  end

  // Forwarding lookup. The scan starts at the oldest stage and ends at the
  // youngest, so the youngest match overrides any older match. Older copies of
  // the same register must never be used once a newer write is in flight.
  function automatic fwd_t lookup(input logic [ADDR_W-1:0] addr,
                                  input entry_t [DEPTH:1]  st);
    fwd_t res;
    res = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (st[k].valid && (st[k].addr == addr)) begin
        res = '0;
        if (int'(st[k].lat) <= k) begin
          res.hit  = 1'b1;
          res.data = st[k].value;
        end else begin
          res.pend = 1'b1;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    w_fwd_a = lookup(fwd_addr_a, r_stage);
    w_fwd_b = lookup(fwd_addr_b, r_stage);
    w_fwd_c = lookup(fwd_addr_c, r_stage);
  end

  assign fwd_hit_a  = w_fwd_a.hit;
  assign fwd_pend_a = w_fwd_a.pend;
  assign fwd_data_a = w_fwd_a.data;
  assign fwd_hit_b  = w_fwd_b.hit;
  assign fwd_pend_b = w_fwd_b.pend;
  assign fwd_data_b = w_fwd_b.data;
  assign fwd_hit_c  = w_fwd_c.hit;
  assign fwd_pend_c = w_fwd_c.pend;
  assign fwd_data_c = w_fwd_c.data;

  // Per-stage state for the issue-hazard checker.
  always_comb begin
    stage_valid = '0;
    stage_addr  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      stage_valid[k-1]                    = r_stage[k].valid;
      stage_addr[(k-1)*ADDR_W +: ADDR_W]  = r_stage[k].addr;
    end
  end

  // Writeback from the last stage. Address and data are masked so that the
  // register-file port is quiet when there is nothing to write.
  assign wb_en   = r_stage[DEPTH].valid;
  assign wb_addr = r_stage[DEPTH].valid ? r_stage[DEPTH].addr  : '0;
  assign wb_data = r_stage[DEPTH].valid ? r_stage[DEPTH].value : '0;

endmodule

// File: tb/tb_ep_result_pipe.sv
module tb_ep_result_pipe;

  logic         clock;
  logic         reset;
  logic [142:0] ep_in;
  logic         flush;
  logic [6:0]   fwd_addr_a, fwd_addr_b, fwd_addr_c;
  logic         fwd_hit_a, fwd_hit_b, fwd_hit_c;
  logic         fwd_pend_a, fwd_pend_b, fwd_pend_c;
  logic [127:0] fwd_data_a, fwd_data_b, fwd_data_c;
  logic [6:0]   stage_valid;
  logic [48:0]  stage_addr;
  logic         wb_en;
  logic [6:0]   wb_addr;
  logic [127:0] wb_data;

  int checks   = 0;
  int failures = 0;

  ep_result_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .ep_in      (ep_in),
    .flush      (flush),
    .fwd_addr_a (fwd_addr_a),
    .fwd_addr_b (fwd_addr_b),
    .fwd_addr_c (fwd_addr_c),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_hit_c  (fwd_hit_c),
    .fwd_pend_a (fwd_pend_a),
    .fwd_pend_b (fwd_pend_b),
    .fwd_pend_c (fwd_pend_c),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
    .fwd_data_c (fwd_data_c),
    .stage_valid(stage_valid),
    .stage_addr (stage_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [142:0] mk(input logic [127:0] value, input logic [6:0] addr,
                                      input logic we, input logic [6:0] lat);
    return {lat, we, addr, value};
  endfunction

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    ep_in = '0;
    flush = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ep_in = '0;
    flush = 1'b0;
    fwd_addr_a = 7'd1; fwd_addr_b = 7'd2; fwd_addr_c = 7'd3;
    #1;
    checks++;
    if ({wb_en, wb_addr, wb_data, stage_valid, stage_addr} !== '0) begin
      failures++;
      $display("FAIL reset_wb_stage: got en=%b addr=%0d data=%0h sv=%b sa=%0h want all 0",
               wb_en, wb_addr, wb_data, stage_valid, stage_addr);
    end
    checks++;
    if ({fwd_hit_a, fwd_hit_b, fwd_hit_c, fwd_pend_a, fwd_pend_b, fwd_pend_c,
         fwd_data_a, fwd_data_b, fwd_data_c} !== '0) begin
      failures++;
      $display("FAIL reset_fwd: hits=%b%b%b pends=%b%b%b want all 0",
               fwd_hit_a, fwd_hit_b, fwd_hit_c, fwd_pend_a, fwd_pend_b, fwd_pend_c);
    end
    @(negedge clock);
    reset = 1'b1;
    // Three valid packets, then reset asserted between edges.
    ep_in = mk(128'd101, 7'd1, 1'b1, 7'd1); tick();
    ep_in = mk(128'd102, 7'd2, 1'b1, 7'd1); tick();
    ep_in = mk(128'd103, 7'd3, 1'b1, 7'd1); tick();
    ep_in = '0;
    checks++;
    if (stage_valid !== 7'b0000111 || fwd_hit_a !== 1'b1 || fwd_data_a !== 128'd101) begin
      failures++;
      $display("FAIL pre_reset_fill: got sv=%b hit_a=%b data_a=%0d want sv=0000111 hit_a=1 data_a=101",
               stage_valid, fwd_hit_a, fwd_data_a);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({stage_valid, stage_addr, wb_en, fwd_hit_a, fwd_hit_b, fwd_hit_c, fwd_data_a} !== '0) begin
      failures++;
      $display("FAIL async_reset: got sv=%b sa=%0h wb_en=%b hits=%b%b%b data_a=%0d want all 0",
               stage_valid, stage_addr, wb_en, fwd_hit_a, fwd_hit_b, fwd_hit_c, fwd_data_a);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (wb_en !== 1'b0 || stage_valid !== 7'b0) begin
        failures++;
        $display("FAIL post_reset_stale cycle %0d: got wb_en=%b sv=%b want 0 0", i, wb_en, stage_valid);
      end
    end
  endtask

  task automatic test_add();
    drain();
    fwd_addr_a = 7'd5;
    ep_in = mk(128'd30, 7'd5, 1'b1, 7'd2);
    tick();
    ep_in = '0;
    for (int s = 1; s <= 7; s++) begin
      checks++;
      if (s == 1) begin
        if ({fwd_hit_a, fwd_pend_a, fwd_data_a} !== {1'b0, 1'b1, 128'd0}) begin
          failures++;
          $display("FAIL add_fwd stage %0d: got hit=%b pend=%b data=%0d want 0 1 0",
                   s, fwd_hit_a, fwd_pend_a, fwd_data_a);
        end
      end else if ({fwd_hit_a, fwd_pend_a, fwd_data_a} !== {1'b1, 1'b0, 128'd30}) begin
        failures++;
        $display("FAIL add_fwd stage %0d: got hit=%b pend=%b data=%0d want 1 0 30",
                 s, fwd_hit_a, fwd_pend_a, fwd_data_a);
      end
      checks++;
      if (s == 7) begin
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 7'd5, 128'd30}) begin
          failures++;
          $display("FAIL add_wb: got en=%b addr=%0d data=%0d want 1 5 30", wb_en, wb_addr, wb_data);
        end
      end else if (wb_en !== 1'b0) begin
        failures++;
        $display("FAIL add_wb_early stage %0d: got en=%b want 0", s, wb_en);
      end
      tick();
    end
    checks++;
    if (wb_en !== 1'b0 || fwd_hit_a !== 1'b0) begin
      failures++;
      $display("FAIL add_retired: got wb_en=%b hit=%b want 0 0", wb_en, fwd_hit_a);
    end
  endtask

  task automatic test_multiply();
    drain();
    fwd_addr_b = 7'd9;
    ep_in = mk(128'd8192, 7'd9, 1'b1, 7'd7);
    tick();
    ep_in = '0;
    for (int s = 1; s <= 7; s++) begin
      checks++;
      if (s < 7) begin
        if ({fwd_hit_b, fwd_pend_b, fwd_data_b, wb_en} !== {1'b0, 1'b1, 128'd0, 1'b0}) begin
          failures++;
          $display("FAIL mul stage %0d: got hit=%b pend=%b data=%0d wb_en=%b want 0 1 0 0",
                   s, fwd_hit_b, fwd_pend_b, fwd_data_b, wb_en);
        end
      end else if ({fwd_hit_b, fwd_pend_b, fwd_data_b, wb_en, wb_addr, wb_data} !==
                   {1'b1, 1'b0, 128'd8192, 1'b1, 7'd9, 128'd8192}) begin
        failures++;
        $display("FAIL mul stage 7: got hit=%b pend=%b data=%0d wb=%b/%0d/%0d want 1 0 8192 1/9/8192",
                 fwd_hit_b, fwd_pend_b, fwd_data_b, wb_en, wb_addr, wb_data);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    drain();
    fwd_addr_c = 7'd12;
    ep_in = mk(128'd7, 7'd12, 1'b1, 7'd2);
    tick();
    ep_in = mk(128'd99, 7'd12, 1'b1, 7'd7);
    tick();
    ep_in = '0;
    // s = stage of the newer packet; the older one is at s+1.
    for (int s = 1; s <= 7; s++) begin
      checks++;
      if (s < 7) begin
        if ({fwd_hit_c, fwd_pend_c, fwd_data_c} !== {1'b0, 1'b1, 128'd0}) begin
          failures++;
          $display("FAIL b2b_fwd stage %0d: got hit=%b pend=%b data=%0d want 0 1 0",
                   s, fwd_hit_c, fwd_pend_c, fwd_data_c);
        end
      end else if ({fwd_hit_c, fwd_pend_c, fwd_data_c} !== {1'b1, 1'b0, 128'd99}) begin
        failures++;
        $display("FAIL b2b_fwd stage 7: got hit=%b pend=%b data=%0d want 1 0 99",
                 fwd_hit_c, fwd_pend_c, fwd_data_c);
      end
      checks++;
      if (s == 6) begin
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 7'd12, 128'd7}) begin
          failures++;
          $display("FAIL b2b_wb_old: got %b/%0d/%0d want 1/12/7", wb_en, wb_addr, wb_data);
        end
      end else if (s == 7) begin
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 7'd12, 128'd99}) begin
          failures++;
          $display("FAIL b2b_wb_new: got %b/%0d/%0d want 1/12/99", wb_en, wb_addr, wb_data);
        end
      end else if (wb_en !== 1'b0) begin
        failures++;
        $display("FAIL b2b_wb_early stage %0d: got en=%b want 0", s, wb_en);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    drain();
    fwd_addr_a = 7'd1;
    fwd_addr_b = 7'd2;
    fwd_addr_c = 7'd3;
    ep_in = mk(128'd11, 7'd1, 1'b1, 7'd1); tick();
    ep_in = mk(128'd22, 7'd2, 1'b1, 7'd1); tick();
    ep_in = mk(128'd33, 7'd3, 1'b1, 7'd1); flush = 1'b1; tick();
    ep_in = '0; flush = 1'b0;
    // s = stage of C.
    for (int s = 1; s <= 7; s++) begin
      checks++;
      if (stage_valid !== 7'(1 << (s - 1))) begin
        failures++;
        $display("FAIL flush_valid stage %0d: got sv=%b want %b", s, stage_valid, 7'(1 << (s - 1)));
      end
      checks++;
      if ({fwd_hit_a, fwd_pend_a, fwd_hit_b, fwd_pend_b, fwd_hit_c, fwd_data_c} !==
          {4'b0000, 1'b1, 128'd33}) begin
        failures++;
        $display("FAIL flush_fwd stage %0d: got a=%b%b b=%b%b c=%b/%0d want a=00 b=00 c=1/33",
                 s, fwd_hit_a, fwd_pend_a, fwd_hit_b, fwd_pend_b, fwd_hit_c, fwd_data_c);
      end
      checks++;
      if (s == 7) begin
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 7'd3, 128'd33}) begin
          failures++;
          $display("FAIL flush_wb_c: got %b/%0d/%0d want 1/3/33", wb_en, wb_addr, wb_data);
        end
      end else if (wb_en !== 1'b0) begin
        failures++;
        $display("FAIL flush_wb_killed stage %0d: got en=%b addr=%0d want 0", s, wb_en, wb_addr);
      end
      if (s == 1) begin
        checks++;
        if (stage_addr[6:0] !== 7'd3) begin
          failures++;
          $display("FAIL flush_stage1_addr: got %0d want 3", stage_addr[6:0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_edge_cases();
    drain();
    // Bubble: write enable 0.
    fwd_addr_a = 7'd20;
    ep_in = mk(128'd55, 7'd20, 1'b0, 7'd1);
    tick();
    ep_in = '0;
    for (int s = 1; s <= 7; s++) begin
      checks++;
      if ({fwd_hit_a, fwd_pend_a, wb_en, stage_valid} !== '0) begin
        failures++;
        $display("FAIL bubble stage %0d: got hit=%b pend=%b wb_en=%b sv=%b want all 0",
                 s, fwd_hit_a, fwd_pend_a, wb_en, stage_valid);
      end
      tick();
    end
    // lat=0 then lat=100 on the next cycle, at address 0 and 22.
    fwd_addr_a = 7'd0;
    fwd_addr_b = 7'd22;
    ep_in = mk(128'd66, 7'd0, 1'b1, 7'd0);
    tick();
    checks++;
    if ({fwd_hit_a, fwd_pend_a, fwd_data_a} !== {1'b1, 1'b0, 128'd66}) begin
      failures++;
      $display("FAIL lat0_stage1: got hit=%b pend=%b data=%0d want 1 0 66",
               fwd_hit_a, fwd_pend_a, fwd_data_a);
    end
    ep_in = mk(128'd77, 7'd22, 1'b1, 7'd100);
    tick();
    ep_in = '0;
    for (int s = 1; s <= 7; s++) begin
      checks++;
      if (s < 7) begin
        if ({fwd_hit_b, fwd_pend_b} !== 2'b01) begin
          failures++;
          $display("FAIL lat100 stage %0d: got hit=%b pend=%b want 0 1", s, fwd_hit_b, fwd_pend_b);
        end
      end else if ({fwd_hit_b, fwd_pend_b, fwd_data_b, wb_en, wb_addr, wb_data} !==
                   {2'b10, 128'd77, 1'b1, 7'd22, 128'd77}) begin
        failures++;
        $display("FAIL lat100 stage 7: got hit=%b pend=%b data=%0d wb=%b/%0d/%0d want 1 0 77 1/22/77",
                 fwd_hit_b, fwd_pend_b, fwd_data_b, wb_en, wb_addr, wb_data);
      end
      if (s == 6) begin
        checks++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 7'd0, 128'd66}) begin
          failures++;
          $display("FAIL lat0_wb_addr0: got %b/%0d/%0d want 1/0/66", wb_en, wb_addr, wb_data);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_multiply();
    test_back_to_back();
    test_flush();
    test_edge_cases();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ep_result_pipe.md
Name: ep_result_pipe

Overview:
- Downstream of `evenpipe`. Captures the 143-bit `out_ep` packet every cycle and carries it through a 7-stage result shift pipeline.
- Holds short-latency results (simple fixed-point, latency 2) alongside long-latency results (multiply, latency 7) in one uniform pipe, so all even-pipe writebacks retire from stage 7 in order.
- Provides operand-forwarding lookup for three source addresses (ra/rb/rc).
- Provides per-stage valid/address visibility for the issue-hazard checker.
- Drives the even-pipe register-file write port.

Parameters:
- DEPTH, 7, number of result stages; writeback is taken from stage DEPTH.
- DATA_W, 128, result value width.
- ADDR_W, 7, register address width (128 registers).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ep_in  in  143  even-pipe packet:
  - [0:127] result value
  - [128:134] rt address
  - [135] write enable
  - [136:142] unit latency, unsigned
- flush  in  1  kills the entries in stages 1 and 2 (younger than a mispredicted branch).
- fwd_addr_a / fwd_addr_b / fwd_addr_c  in  7 each  source register addresses queried by the operand stage.
- fwd_hit_a / fwd_hit_b / fwd_hit_c  out  1 each  forwarding data is available.
- fwd_pend_a / fwd_pend_b / fwd_pend_c  out  1 each  youngest matching producer is not yet ready (RAW hazard).
- fwd_data_a / fwd_data_b / fwd_data_c  out  128 each  forwarded value; 0 when hit=0.
- stage_valid  out  7  bit k-1 = stage k holds a live write.
- stage_addr  out  49  stage k rt address at bits [(k-1)*7 : (k-1)*7+6].
- wb_en  out  1  register-file write enable.
- wb_addr  out  7  register-file write address.
- wb_data  out  128  register-file write data.

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits clear, values/addresses/latencies clear. Consequently:
  - wb_en=0, wb_addr=0, wb_data=0
  - stage_valid=0, stage_addr=0
  - all fwd_hit, fwd_pend and fwd_data outputs read 0
- Reset release: the first rising edge with reset=1 captures ep_in normally.
- Each stage entry holds {value, addr, valid, lat}.
  - valid = ep_in[135] at capture.
  - lat = ep_in[136:142], normalised:
    - 0 becomes 1
    - values greater than 7 saturate to 7
    - 1..7 pass unchanged
- Each rising edge:
  - stage1 <= ep_in
  - stage k <= stage k-1 for k = 2..7
  - stage 7 is consumed by writeback.
  - No stall; the pipe advances every cycle.
- Latency: a packet presented before edge N occupies stage k after edge N+k-1.
- Writeback: wb_en/wb_addr/wb_data are driven combinationally from stage 7 (registered state).
  - wb_en = stage7.valid.
  - A packet therefore writes back 7 cycles after capture, regardless of lat.
  - wb_addr and wb_data are 0 when stage 7 is not valid.
- Ready rule: stage k entry is ready iff valid and k >= lat.
- Forwarding, per port x, combinational:
  - Scan stages 1..7 for valid entries with addr == fwd_addr_x.
  - The youngest match (lowest k) decides the result; older matches are ignored.
  - Youngest match ready: fwd_hit_x=1, fwd_pend_x=0, fwd_data_x = that value.
  - Youngest match not ready: fwd_hit_x=0, fwd_pend_x=1, fwd_data_x=0.
  - No match: all three outputs are 0.
- Writeback/forward same cycle: a stage-7 entry is still forwardable in the cycle it writes back (the register file write is not yet visible).
- Flush, synchronous, sampled at the rising edge:
  - The entries that would land in stages 2 and 3 (current stage1 and stage2) have their valid cleared.
  - The incoming ep_in is still captured into stage 1.
  - Flush and reset together: reset wins.
- Write enable 0 packets: propagate as bubbles (valid=0). They are never forwarded and never written back.
- Address 0 is an ordinary register; no special case.
- Repeated writes to the same address in flight: every write retires, in order; forwarding always returns the youngest ready copy.

Test Plan:
- Reset mid-stream: inject 3 valid packets, assert reset=0 between clock edges -> outputs go to 0 immediately, without waiting for an edge; after release, no stale wb_en for 7 cycles.
- ADD_WORD, ra=20, rb=10, packet {value=30, addr=5, wr=1, lat=2}:
  - wb_en=1, wb_addr=5, wb_data=30 exactly 7 cycles after capture.
  - fwd_addr_a=5: fwd_pend_a=1 while in stage 1; fwd_hit_a=1 with data 30 from stage 2 onward.
- MULTIPLY, ra=64, rb=128, packet {value=8192, addr=9, lat=7}: fwd_pend=1 for stages 1..6; fwd_hit=1 only at stage 7, in the same cycle as wb_en=1.
- Back-to-back writes to addr 12:
  - Older packet (value 7, lat 2) followed next cycle by newer packet (value 99, lat 7).
  - Query 12 -> fwd_pend=1 (youngest match wins), never value 7.
  - wb sequence: 7, then 99.
- Flush: packets A (addr 1), B (addr 2), C (addr 3) captured in consecutive cycles; assert flush with the edge capturing C -> A and B never write back; C writes back; stage_valid shows only C.
- Bubble and latency edge cases:
  - Packet with wr=0 -> wb_en stays 0 and the address never forwards.
  - Packet with lat=0 -> ready in stage 1.
  - Packet with lat=100 -> treated as 7.
